// File: rtl/uart_rx.sv
// 8N1-style UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// registered valid/ready output with frame-error and overrun pulses.
module uart_rx #(
    parameter int unsigned F    = 8000000,
    parameter int unsigned BAUD = 115200,
    parameter int unsigned N    = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    output logic [N-1:0] data,
    output logic         valid,
    input  logic         ready,
    output logic         frame_err,
    output logic         overrun
);

    localparam int unsigned P  = (F + BAUD / 2) / BAUD;
    localparam int unsigned H  = P / 2;
    localparam int unsigned CW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N + 1) : 1;

    localparam logic [CW-1:0] CntBitEnd  = CW'(P - 1);
    localparam logic [CW-1:0] CntHalfEnd = CW'(H - 1);
    localparam logic [IW-1:0] IdxLast    = IW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  shift_q, shift_d;
    logic          armed_q, armed_d;

    logic          sync_q, rx_s_q;

    logic [N-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;

    logic          stop_tick;

    // Line idles high, so both synchronizer stages reset to 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 1'b1;
            rx_s_q <= 1'b1;
        end else begin
            sync_q <= rx;
            rx_s_q <= sync_q;
        end
    end

    // State register, including the datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            armed_q     <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        armed_d = armed_q;

        unique case (state_q)
            StIdle: begin
                // A start edge is only accepted after the line has been seen high.
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end
                if (armed_q && !rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end

            StStart: begin
                if (cnt_q == CntHalfEnd) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StData;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            StData: begin
                if (cnt_q == CntBitEnd) begin
                    cnt_d   = '0;
                    shift_d = N'({rx_s_q, shift_q} >> 1);
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IdxLast) begin
                        state_d = StStop;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            StStop: begin
                if (cnt_q == CntBitEnd) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    // A low stop bit (break) must see the line high again before rearming.
                    if (!rx_s_q) begin
                        armed_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign stop_tick = (state_q == StStop) && (cnt_q == CntBitEnd);

    // Output logic: handshake, word load and status pulses.
    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (valid_q && ready) begin
            valid_d = 1'b0;
        end

        if (stop_tick) begin
            if (rx_s_q) begin
                // A word consumed on this same edge frees the slot for the new one.
                if (!valid_q || ready) begin
                    data_d  = shift_q;
                    valid_d = 1'b1;
                end else begin
                    overrun_d = 1'b1;
                end
            end else begin
                frame_err_d = 1'b1;
            end
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames plus a cycle-level model of the sampling
// schedule, compared against the DUT outputs on every falling clock edge.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int unsigned F    = 8000000;
    localparam int unsigned BAUD = 115200;
    localparam int unsigned N    = 8;
    localparam int P        = (F + BAUD / 2) / BAUD;
    localparam int H        = P / 2;
    // Clock edges from driving the start bit low to the stop-bit sample edge.
    localparam int STOP_OFF = 3 + H + (N + 1) * P;

    logic         clk;
    logic         rst;
    logic         rx;
    logic         ready;
    logic [N-1:0] data;
    logic         valid;
    logic         frame_err;
    logic         overrun;

    uart_rx #(
        .F   (F),
        .BAUD(BAUD),
        .N   (N)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;
    logic cmp_en = 1'b0;

    // Behavioural model state
    logic         m_h1 = 1'b1, m_h2 = 1'b1;
    logic         m_armed = 1'b0, m_busy = 1'b0;
    int           m_t = 0;
    logic [N-1:0] m_sh = '0;
    logic [N-1:0] m_data = '0;
    logic         m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

    // Monitor state
    logic [7:0] rx_q[$];
    int acc_cnt = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: the line is seen two edges late; once a start edge is taken at edge k0,
    // the start bit is judged at k0+H, data bit j at k0+H+(j+1)P, stop at k0+H+(N+1)P.
    initial begin : model
        logic rxs;
        logic loaded;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_h1 = 1'b1; m_h2 = 1'b1; m_armed = 1'b0; m_busy = 1'b0; m_t = 0;
                m_data = '0; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
            end else begin
                rxs = m_h2;
                m_h2 = m_h1;
                m_h1 = rx;
                m_fe = 1'b0;
                m_ov = 1'b0;
                loaded = 1'b0;
                if (!m_busy) begin
                    if (m_armed && !rxs) begin
                        m_busy = 1'b1;
                        m_t = 0;
                    end else if (rxs) begin
                        m_armed = 1'b1;
                    end
                end else begin
                    m_t++;
                    if (m_t == H) begin
                        if (rxs) m_busy = 1'b0;
                    end else if (m_t > H && (m_t - H) % P == 0 && (m_t - H) / P <= N) begin
                        m_sh[(m_t - H) / P - 1] = rxs;
                    end else if (m_t == H + (N + 1) * P) begin
                        m_busy = 1'b0;
                        if (rxs) begin
                            if (!m_valid || ready) begin
                                m_data = m_sh;
                                m_valid = 1'b1;
                                loaded = 1'b1;
                            end else begin
                                m_ov = 1'b1;
                            end
                        end else begin
                            m_fe = 1'b1;
                            m_armed = 1'b0;
                        end
                    end
                end
                if (!loaded && m_valid && ready) m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (valid !== m_valid || data !== m_data || frame_err !== m_fe ||
                overrun !== m_ov) begin
                errors++;
                if (fail_prints < 20) begin
                    fail_prints++;
                    $display("FAIL cycle_compare t=%0t: got valid=%b data=%h fe=%b ov=%b, expected valid=%b data=%h fe=%b ov=%b",
                             $time, valid, data, frame_err, overrun,
                             m_valid, m_data, m_fe, m_ov);
                end
            end
        end
        if (valid === 1'b1 && ready === 1'b1) begin
            rx_q.push_back(data);
            acc_cnt++;
        end
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    // All drive tasks start and end just after a rising edge.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (per) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    logic [7:0] clean[4] = '{8'h55, 8'h00, 8'hFF, 8'hA3};
    logic [7:0] exp_q[$];
    int n0, fe0, ov0;
    logic [9:0] rf;

    initial begin
        rx = 1'b1;
        ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", valid, 0);
        check("reset_data", data, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        idle(5);

        // Clean frames
        for (int i = 0; i < 4; i++) begin
            n0 = acc_cnt;
            send_frame(clean[i], 1'b1, P);
            idle(P);
            check("clean_accept_count", acc_cnt - n0, 1);
            check("clean_data", rx_q[$], clean[i]);
        end
        check("clean_no_frame_err", fe_cnt, 0);
        check("clean_no_overrun", ov_cnt, 0);

        // Start-bit glitch
        n0 = acc_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        idle(3 * P);
        check("glitch_no_valid", acc_cnt - n0, 0);
        check("glitch_no_frame_err", fe_cnt - fe0, 0);
        send_frame(8'h3C, 1'b1, P);
        idle(P);
        check("glitch_then_frame", rx_q[$], 8'h3C);
        check("glitch_then_count", acc_cnt - n0, 1);

        // Bad stop bit followed by a held break
        n0 = acc_cnt; fe0 = fe_cnt;
        send_frame(8'h81, 1'b0, P);
        rx = 1'b0;
        repeat (2 * P) @(posedge clk);
        #1;
        idle(2 * P);
        check("badstop_frame_err_once", fe_cnt - fe0, 1);
        check("badstop_no_valid", acc_cnt - n0, 0);
        check("badstop_valid_low", valid, 0);
        send_frame(8'h81, 1'b1, P);
        idle(P);
        check("badstop_recover", rx_q[$], 8'h81);
        check("badstop_recover_fe", fe_cnt - fe0, 1);

        // Overrun
        ready = 1'b0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, P);
        send_frame(8'h22, 1'b1, P);
        idle(P);
        check("overrun_valid", valid, 1);
        check("overrun_data_kept", data, 8'h11);
        check("overrun_pulse", ov_cnt - ov0, 1);
        pulse_ready();
        check("overrun_drain", valid, 0);

        // Consumer takes the old word on the exact stop-sample edge of the next one
        send_frame(8'h11, 1'b1, P);
        idle(P);
        check("samecycle_pre_valid", valid, 1);
        ov0 = ov_cnt;
        fork
            send_frame(8'h22, 1'b1, P);
            begin
                repeat (STOP_OFF - 1) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        idle(P);
        check("samecycle_data", data, 8'h22);
        check("samecycle_valid", valid, 1);
        check("samecycle_no_overrun", ov_cnt - ov0, 0);
        pulse_ready();
        check("samecycle_drain", valid, 0);

        // Reset during data bit 3
        send_frame(8'h77, 1'b1, P);
        idle(P);
        check("premrst_valid", valid, 1);
        rf = {1'b1, 8'h5A, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx = rf[i];
            repeat (P) @(posedge clk);
            #1;
        end
        rx = rf[4];
        repeat (P / 2) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_data", data, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        rx = 1'b1;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        idle(20);
        send_frame(8'h5A, 1'b1, P);
        idle(P);
        check("postrst_data", rx_q[$], 8'h5A);

        // Back-to-back stream, including slightly fast and slow transmitters
        rx_q.delete();
        fe0 = fe_cnt; ov0 = ov_cnt;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i * 17));
            send_frame(8'(i * 17), 1'b1, P);
        end
        exp_q.push_back(8'h96);
        send_frame(8'h96, 1'b1, P - 1);
        exp_q.push_back(8'h69);
        send_frame(8'h69, 1'b1, P + 1);
        idle(2 * P);
        check("stream_count", rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check("stream_byte", (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
        end
        check("stream_no_frame_err", fe_cnt - fe0, 0);
        check("stream_no_overrun", ov_cnt - ov0, 0);

        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
